datapath_issuer: RTL and testbench

DATAPATH_ISSUER -- requirements
Module: datapath_issuer

---
 rtl/datapath_issuer.sv | 249 ++++++++++++++++++++++++
 tb/tb_datapath_issuer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_issuer.sv
// ---------------------------------------------------------------------------
// datapath_issuer
//
// Buffers operand bundles in a small FIFO and issues them one at a time to
// an attached add/subtract datapath. The datapath has PIPE input-register
// stages and reads dp_op combinationally. For that reason dp_a, dp_b and
// dp_op are held until the result has been captured. Each result waits in
// out_y/out_co until the consumer takes it, so results leave strictly in
// acceptance order.
//
// Parameters
//   N     operand/result width
//   PIPE  datapath input-register latency (0 or 1)
//   DEPTH operand FIFO entries (power of 2, >= 2)
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand bundle handshake (in_a, in_b, in_op)
//   dp_a, dp_b, dp_op   operands/opcode driven to the datapath
//   dp_y, dp_co         datapath result and carry-out
//   out_valid/out_ready result handshake (out_y, out_co)
//   busy                FIFO non-empty or an operation in progress
//   err                 sticky result-mismatch flag
//
// Optional feature: define ISSUER_CHECK_EN to build an internal reference
// adder. The reference flags any datapath result that disagrees with it.
// Without the macro, err is tied low and no checker logic exists.
// ---------------------------------------------------------------------------
module datapath_issuer #(
    parameter int N     = 16,
    parameter int PIPE  = 1,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [2:0]   in_op,
    output logic [N-1:0] dp_a,
    output logic [N-1:0] dp_b,
    output logic [2:0]   dp_op,
    input  logic [N-1:0] dp_y,
    input  logic         dp_co,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_y,
    output logic         out_co,
    output logic         busy,
    output logic         err
);

    localparam int   AW       = $clog2(DEPTH);
    localparam int   CW       = AW + 1;
    localparam logic CNT_LOAD = (PIPE != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // FIFO storage and bookkeeping
    logic [N-1:0]  fifo_a_r  [DEPTH];
    logic [N-1:0]  fifo_b_r  [DEPTH];
    logic [2:0]    fifo_op_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    // Control state
    state_t        state_r;
    logic          cnt_r;
    logic          in_ready_r;
    logic          busy_r;
    logic [N-1:0]  dp_a_r;
    logic [N-1:0]  dp_b_r;
    logic [2:0]    dp_op_r;
    logic [N-1:0]  out_y_r;
    logic          out_co_r;
    logic          out_valid_r;

    logic          empty_s;
    logic          push_s;
    logic          pop_s;
    logic          capture_s;
    logic [CW-1:0] count_nxt_s;
    logic          busy_nxt_s;

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign dp_a      = dp_a_r;
    assign dp_b      = dp_b_r;
    assign dp_op     = dp_op_r;
    assign out_y     = out_y_r;
    assign out_co    = out_co_r;
    assign out_valid = out_valid_r;

    // Handshake decode, occupancy update and next-cycle busy flag
    always_comb begin
        empty_s     = (count_r == CW'(0));
        // in_ready_r mirrors !full, so a full FIFO refuses a push even
        // when a pop happens in the same cycle.
        push_s      = in_valid && in_ready_r;
        pop_s       = !empty_s &&
                      ((state_r == ST_IDLE) ||
                       ((state_r == ST_HOLD) && out_ready));
        capture_s   = (state_r == ST_WAIT) && (cnt_r == 1'b0);
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CW'(1);
        end else if (!push_s && pop_s) begin
            count_nxt_s = count_r - CW'(1);
        end else begin
            count_nxt_s = count_r;
        end
        // Busy next cycle: entries remain, or the FSM will not be in IDLE.
        busy_nxt_s  = (count_nxt_s != CW'(0)) || pop_s ||
                      (state_r == ST_WAIT) ||
                      ((state_r == ST_HOLD) && !(out_ready && empty_s));
    end

    // FIFO entry storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_a_r[wr_ptr_r]  <= in_a;
            fifo_b_r[wr_ptr_r]  <= in_b;
            fifo_op_r[wr_ptr_r] <= in_op;
        end
    end

    // FIFO pointers, occupancy and registered in_ready/busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            // DEPTH is a power of 2, so plain increment wraps correctly.
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r    <= count_nxt_s;
            in_ready_r <= (count_nxt_s != CW'(DEPTH));
            busy_r     <= busy_nxt_s;
        end
    end

    // Issue FSM: IDLE -> WAIT (datapath settling) -> HOLD (result offered)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 1'b0;
            dp_a_r      <= {N{1'b0}};
            dp_b_r      <= {N{1'b0}};
            dp_op_r     <= 3'b000;
            out_y_r     <= {N{1'b0}};
            out_co_r    <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        dp_a_r  <= fifo_a_r[rd_ptr_r];
                        dp_b_r  <= fifo_b_r[rd_ptr_r];
                        dp_op_r <= fifo_op_r[rd_ptr_r];
                        cnt_r   <= CNT_LOAD;
                        state_r <= ST_WAIT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r != 1'b0) begin
                        cnt_r <= cnt_r - 1'b1;
                    end else begin
                        out_y_r     <= dp_y;
                        out_co_r    <= dp_co;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        if (pop_s) begin
                            // Back-to-back issue without visiting IDLE.
                            dp_a_r  <= fifo_a_r[rd_ptr_r];
                            dp_b_r  <= fifo_b_r[rd_ptr_r];
                            dp_op_r <= fifo_op_r[rd_ptr_r];
                            cnt_r   <= CNT_LOAD;
                            state_r <= ST_WAIT;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ISSUER_CHECK_EN
    logic err_r;

    // Reference result: a + (op[2] ? 0 : op[1] ? ~b : b) + op[0], N+1 bits
    function automatic logic [N:0] ref_sum(input logic [N-1:0] a,
                                           input logic [N-1:0] b,
                                           input logic [2:0]   op);
        logic [N-1:0] b_sel;
        if (op[2]) begin
            b_sel = {N{1'b0}};
        end else if (op[1]) begin
            b_sel = ~b;
        end else begin
            b_sel = b;
        end
        return {1'b0, a} + {1'b0, b_sel} + {{N{1'b0}}, op[0]};
    endfunction

    // Sticky mismatch flag, evaluated at the moment a result is captured
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (capture_s &&
                     (ref_sum(dp_a_r, dp_b_r, dp_op_r) != {dp_co, dp_y})) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_datapath_issuer.sv
// ---------------------------------------------------------------------------
// tb_datapath_issuer
//
// Directed self-checking bench for datapath_issuer (N=16, PIPE=1, DEPTH=4).
// A behavioural datapath with one input-register stage sits on the dp_*
// ports. A fault-injection control makes it return a wrong result so the
// sticky error flag can be exercised.
// ---------------------------------------------------------------------------
module tb_datapath_issuer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [2:0]  in_op;
    logic [15:0] dp_a;
    logic [15:0] dp_b;
    logic [2:0]  dp_op;
    logic [15:0] dp_y;
    logic        dp_co;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_y;
    logic        out_co;
    logic        busy;
    logic        err;

    int n_checks;
    int n_pass;

    // Datapath model state
    logic [15:0] dpq_a;
    logic [15:0] dpq_b;
    logic [2:0]  dpq_op;
    logic [16:0] dp_sum;
    logic        dp_bad;

    // Directed vector table with hand-computed results
    logic [15:0] va   [5];
    logic [15:0] vb   [5];
    logic [2:0]  vop  [5];
    logic [15:0] vy   [5];
    logic        vco  [5];

    datapath_issuer #(.N(16), .PIPE(1), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .dp_a      (dp_a),
        .dp_b      (dp_b),
        .dp_op     (dp_op),
        .dp_y      (dp_y),
        .dp_co     (dp_co),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_co    (out_co),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath input register (PIPE = 1)
    always_ff @(posedge clk) begin
        dpq_a  <= dp_a;
        dpq_b  <= dp_b;
        dpq_op <= dp_op;
    end

    // Datapath arithmetic, optionally corrupted by +1
    always_comb begin
        dp_sum = {1'b0, dpq_a}
               + {1'b0, (dpq_op[2] ? 16'h0000 : (dpq_op[1] ? ~dpq_b : dpq_b))}
               + {16'h0000, dpq_op[0]};
        dp_y   = dp_sum[15:0] + (dp_bad ? 16'h0001 : 16'h0000);
        dp_co  = dp_sum[16];
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one bundle into an idle issuer, check latency and result
    task automatic run_op(input string tag, input logic [15:0] a,
                          input logic [15:0] b, input logic [2:0] op,
                          input logic [15:0] ey, input logic eco);
        int lat;
        @(negedge clk);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'd3);
        check_eq({tag, "_y"}, {16'h0000, out_y}, {16'h0000, ey});
        check_eq({tag, "_co"}, {31'd0, out_co}, {31'd0, eco});
        check_eq({tag, "_dp_op_held"}, {29'd0, dp_op}, {29'd0, op});
        @(negedge clk);
        check_eq({tag, "_consumed"}, {31'd0, out_valid}, 32'd0);
    endtask

    // Hold in_valid high with out_ready low; returns accepted bundle count
    task automatic fill(output int accepted);
        logic pending;
        accepted  = 0;
        pending   = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (pending) accepted++;
            in_valid = 1'b1;
            in_a     = va[(accepted < 5) ? accepted : 4];
            in_b     = vb[(accepted < 5) ? accepted : 4];
            in_op    = vop[(accepted < 5) ? accepted : 4];
            pending  = in_ready;
        end
        @(negedge clk);
        if (pending) accepted++;
        in_valid = 1'b0;
    endtask

    initial begin
        int acc;
        int got;
        int seen;
        n_checks  = 0;
        n_pass    = 0;
        dp_bad    = 1'b0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_a      = 16'h0000;
        in_b      = 16'h0000;
        in_op     = 3'b000;
        out_ready = 1'b0;

        va[0] = 16'h0001; vb[0] = 16'h0002; vop[0] = 3'b000; vy[0] = 16'h0003; vco[0] = 1'b0;
        va[1] = 16'hFFFF; vb[1] = 16'h0001; vop[1] = 3'b000; vy[1] = 16'h0000; vco[1] = 1'b1;
        va[2] = 16'h0010; vb[2] = 16'h0004; vop[2] = 3'b011; vy[2] = 16'h000C; vco[2] = 1'b1;
        va[3] = 16'h1234; vb[3] = 16'h5555; vop[3] = 3'b100; vy[3] = 16'h1234; vco[3] = 1'b0;
        va[4] = 16'h00FF; vb[4] = 16'h00F0; vop[4] = 3'b010; vy[4] = 16'h000E; vco[4] = 1'b1;

        // Reset state
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_dp", {dp_a, dp_b[12:0], dp_op}, 32'd0);
        check_eq("rst_out", {15'd0, out_co, out_y}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rel_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rel_busy", {31'd0, busy}, 32'd0);

        // Basic arithmetic
        run_op("add", 16'h0005, 16'h0003, 3'b000, 16'h0008, 1'b0);
        run_op("sub", 16'h0005, 16'h0003, 3'b011, 16'h0002, 1'b1);
        run_op("sub_wrap", 16'h0000, 16'h0001, 3'b011, 16'hFFFF, 1'b0);
        run_op("inc_zero_b", 16'h7FFF, 16'h1111, 3'b101, 16'h8000, 1'b0);

        // Fill and backpressure
        fill(acc);
        check_eq("fill_accepted", 32'(acc), 32'd5);
        check_eq("fill_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            check_eq("hold_stable", {14'd0, out_valid, out_co, out_y},
                     {14'd0, 1'b1, vco[0], vy[0]});
            @(negedge clk);
        end

        // Drain in order
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 100 && got < 5; c++) begin
            if (out_valid) begin
                check_eq("drain_result", {15'd0, out_co, out_y},
                         {15'd0, vco[got], vy[got]});
                got++;
            end
            @(negedge clk);
        end
        check_eq("drain_count", 32'(got), 32'd5);
        @(negedge clk);
        @(negedge clk);
        check_eq("drain_busy", {31'd0, busy}, 32'd0);
        check_eq("drain_no_extra", {31'd0, out_valid}, 32'd0);

        // Reset while in WAIT with 3 entries queued
        fill(acc);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        check_eq("midrst_dp_a", {16'h0000, dp_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("midrst_empty", {31'd0, busy}, 32'd0);
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid || busy) seen++;
        end
        check_eq("midrst_no_output", 32'(seen), 32'd0);
        run_op("post_rst_add", 16'h0100, 16'h0023, 3'b000, 16'h0123, 1'b0);

        // Checker: datapath returns 0x1235 instead of 0x1234
        dp_bad = 1'b1;
        run_op("bad_dp", 16'h1234, 16'h0000, 3'b100, 16'h1235, 1'b0);
        dp_bad = 1'b0;
`ifdef ISSUER_CHECK_EN
        check_eq("err_set", {31'd0, err}, 32'd1);
`else
        check_eq("err_tied", {31'd0, err}, 32'd0);
`endif
        run_op("good_after_bad", 16'h0005, 16'h0003, 3'b000, 16'h0008, 1'b0);
`ifdef ISSUER_CHECK_EN
        check_eq("err_sticky", {31'd0, err}, 32'd1);
`else
        check_eq("err_still_tied", {31'd0, err}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
